// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC generation into a small in-order
// instruction queue, with redirect flush and a delivered-instruction counter.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] fetch_count
);

  localparam int          CW       = $clog2(QDEPTH + 1);
  localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

  logic [31:0]   fpc_reg;
  logic [31:0]   fetch_count_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [CW-1:0] keep_count;
  logic [31:0]   word_q [QDEPTH];
  logic [31:0]   pc_q   [QDEPTH];
  logic          pop;
  logic          push;
  logic          shift;
  logic          full;

  assign instr_valid = (count_reg != '0);
  assign full        = (count_reg == CW'(QDEPTH));
  assign pop         = instr_valid & instr_ready;
  // A pop frees a slot in the same cycle, so a full queue can still accept.
  assign push        = ~redirect & (~full | pop);
  assign shift       = pop & ~redirect;
  assign keep_count  = count_reg - CW'(pop);

  always_comb begin
    count_next = keep_count + CW'(push);
    if (redirect) begin
      count_next = '0;
    end
  end

  // Entry 0 is always the head; a pop shifts the survivors down one slot.
  // Slots are left untouched when the queue drains, so the head keeps its
  // last contents while instr_valid is low.
  generate
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
      logic [31:0] word_reg;
      logic [31:0] pc_reg;
      logic [31:0] src_word;
      logic [31:0] src_pc;

      assign word_q[gi] = word_reg;
      assign pc_q[gi]   = pc_reg;

      if (gi < QDEPTH - 1) begin : g_mid
        assign src_word = word_q[gi+1];
        assign src_pc   = pc_q[gi+1];
      end else begin : g_last
        assign src_word = word_reg;
        assign src_pc   = pc_reg;
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          word_reg <= '0;
          pc_reg   <= '0;
        end else if (push && (keep_count == CW'(gi))) begin
          word_reg <= imem_data;
          pc_reg   <= fpc_reg;
        end else if (shift && (CW'(gi + 1) < count_reg)) begin
          word_reg <= src_word;
          pc_reg   <= src_pc;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fpc_reg         <= START_PC;
      count_reg       <= '0;
      fetch_count_reg <= '0;
    end else begin
      count_reg       <= count_next;
      fetch_count_reg <= fetch_count_reg + 32'(pop);
      if (redirect) begin
        fpc_reg <= {redirect_pc[31:2], 2'b00};
      end else if (push) begin
        fpc_reg <= fpc_reg + 32'd4;
      end
    end
  end

  assign imem_addr   = fpc_reg;
  assign instr       = word_q[0];
  assign instr_pc    = pc_q[0];
  assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// ready/redirect traffic against a queue-based reference model.
module tb_fetch_unit;

  localparam int          QDEPTH   = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] fetch_count;

  fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h1111_1111;
    if (a == 32'h4) return 32'h2222_2222;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  assign imem_data = mem_word(imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_fpc, m_fc, disp_pc, disp_word;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_fpc     = {RESET_PC[31:2], 2'b00};
    m_fc      = 32'h0;
    disp_pc   = 32'h0;
    disp_word = 32'h0;
  endtask

  task automatic model_step();
    if (q.size() > 0 && instr_ready) begin
      q.delete(0);
      m_fc = m_fc + 1;
    end
    if (redirect) begin
      q.delete();
      m_fpc = {redirect_pc[31:2], 2'b00};
    end else if (q.size() < QDEPTH) begin
      q.push_back('{m_fpc, mem_word(m_fpc)});
      m_fpc = m_fpc + 4;
    end
    if (q.size() > 0) begin
      disp_pc   = q[0].pc;
      disp_word = q[0].word;
    end
  endtask

  task automatic compare_all();
    check("valid", 32'(instr_valid), 32'(q.size() > 0));
    check("instr", instr, disp_word);
    check("instr_pc", instr_pc, disp_pc);
    check("imem_addr", imem_addr, m_fpc);
    check("fetch_count", fetch_count, m_fc);
  endtask

  // Advance one clock: model follows the edge, outputs checked at the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    @(negedge clk);
    compare_all();
    $display("cyc t=%0t rdy=%0b redir=%0b v=%0b pc=%08h instr=%08h addr=%08h cnt=%0d",
             $time, instr_ready, redirect, instr_valid, instr_pc, instr, imem_addr, fetch_count);
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    model_reset();
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n     = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    model_reset();

    // Reset state and first deliveries
    @(negedge clk);
    compare_all();
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    reset_n     = 1'b1;
    instr_ready = 1'b1;
    cycle();
    check("c1_instr", instr, 32'h1111_1111);
    check("c1_pc", instr_pc, 32'h0);
    check("c1_cnt", fetch_count, 32'h0);
    cycle();
    check("c2_instr", instr, 32'h2222_2222);
    check("c2_pc", instr_pc, 32'h4);
    check("c2_cnt", fetch_count, 32'h1);
    cycle();
    check("c3_cnt", fetch_count, 32'h2);

    // Backpressure fills the queue and stalls fetch
    reset_pulse();
    instr_ready = 1'b0;
    repeat (5) cycle();
    check("bp_addr", imem_addr, 32'h8);
    check("bp_pc", instr_pc, 32'h0);
    check("bp_instr", instr, 32'h1111_1111);
    instr_ready = 1'b1;
    cycle();
    check("bp_pc4", instr_pc, 32'h4);
    cycle();
    check("bp_pc8", instr_pc, 32'h8);

    // Redirect flushes a full queue
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h10;
    cycle();
    redirect = 1'b0;
    cycle();
    cycle();
    check("fl_head", instr_pc, 32'h10);
    redirect    = 1'b1;
    redirect_pc = 32'h43;
    cycle();
    check("fl_valid", 32'(instr_valid), 32'h0);
    check("fl_addr", imem_addr, 32'h40);
    redirect    = 1'b0;
    instr_ready = 1'b1;
    cycle();
    check("fl_pc40", instr_pc, 32'h40);
    check("fl_v", 32'(instr_valid), 32'h1);
    cycle();
    check("fl_pc44", instr_pc, 32'h44);

    // Address wrap-around
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect = 1'b0;
    cycle();
    check("wr_top", instr_pc, 32'hFFFF_FFFC);
    cycle();
    check("wr_0", instr_pc, 32'h0);
    cycle();
    check("wr_4", instr_pc, 32'h4);

    // Asynchronous reset between edges while full
    instr_ready = 1'b0;
    repeat (3) cycle();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("ar_valid", 32'(instr_valid), 32'h0);
    check("ar_instr", instr, 32'h0);
    check("ar_cnt", fetch_count, 32'h0);
    check("ar_addr", imem_addr, 32'h0);
    #1;
    reset_n = 1'b1;
    cycle();
    check("ar_pc", instr_pc, 32'h0);
    check("ar_v", 32'(instr_valid), 32'h1);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else redirect_pc = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; bits [1:0] SHALL be treated as zero.
REQ-002 Parameter QDEPTH, default 2: instruction queue depth in entries; legal values are 2 or 4.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 imem_addr  output  32  byte address to instruction memory; the memory returns the big-endian word at this address combinationally, in the same cycle.
REQ-006 imem_data  input  32  instruction word returned for imem_addr.
REQ-007 redirect  input  1  branch/jump taken; flush the queue and restart fetch.
REQ-008 redirect_pc  input  32  target address, valid when redirect=1.
REQ-009 instr_valid  output  1  queue head holds a valid instruction.
REQ-010 instr_ready  input  1  downstream decode accepts the head this cycle.
REQ-011 instr  output  32  instruction word at the queue head.
REQ-012 instr_pc  output  32  byte address of instr.
REQ-013 fetch_count  output  32  number of instructions delivered (handshakes completed), wrapping.

Function
REQ-014 Fetch PC register (fpc): imem_addr SHALL equal fpc every cycle; fpc[1:0] SHALL always be 0.
REQ-015 Push: when redirect=0 and the queue is not full, or it is full and a pop occurs in the same cycle, {imem_data, fpc} SHALL be written at the tail at the clock edge, and fpc SHALL advance by 4.
REQ-016 No push (queue full, no pop): fpc and imem_addr SHALL hold.
REQ-017 Pop: a handshake is instr_valid=1 and instr_ready=1; the head SHALL retire at the edge and fetch_count SHALL increment by 1.
REQ-018 instr and instr_pc SHALL come directly from the head entry registers, with no combinational path from imem_data or instr_ready.
REQ-019 Latency: a word present on imem_data at edge N SHALL appear on instr at cycle N+1 if the queue was empty.
REQ-020 Ordering: instructions SHALL be delivered in fetch order with no duplicates and no gaps.
REQ-021 Redirect: at the edge with redirect=1, the queue SHALL be emptied (instr_valid=0 in the next cycle), no push SHALL occur, and fpc SHALL be loaded with {redirect_pc[31:2],2'b00}.
REQ-022 Redirect with a simultaneous handshake: the pop SHALL count in fetch_count; redirect takes priority over the push.
REQ-023 Wrap-around: fpc=32'hFFFF_FFFC SHALL advance to 32'h0000_0000.
REQ-024 Occupancy: an internal count SHALL track 0..QDEPTH; a simultaneous push and pop SHALL leave the count unchanged.
REQ-025 Empty: instr_valid=0; instr and instr_pc hold their last values; instr_ready is ignored.
REQ-026 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.

Reset
REQ-027 reset_n=0 SHALL immediately, without a clock edge, set fpc=RESET_PC (low bits cleared), set imem_addr=RESET_PC, empty the queue, and set instr_valid=0, instr=0, instr_pc=0, fetch_count=0.
REQ-028 Reset asserted mid-operation SHALL discard all queued entries; no instruction SHALL be delivered until after release.
REQ-029 After reset_n rises, the first rising edge SHALL push the word at RESET_PC; instr_valid SHALL be 1 in the following cycle.

Verification
REQ-030 Reset release, RESET_PC=0, imem words 0x11111111 at 0x0 and 0x22222222 at 0x4, instr_ready=1 -> cycle 1: instr=0x11111111, instr_pc=0; cycle 2: instr=0x22222222, instr_pc=4; fetch_count increments once per cycle.
REQ-031 instr_ready=0 for 5 cycles, QDEPTH=2 -> queue fills after 2 edges; imem_addr holds 0x8; instr holds the 0x0 entry; then instr_ready=1 -> pcs 0,4,8 delivered in order.
REQ-032 Queue holding pcs 0x10 and 0x14, redirect=1, redirect_pc=0x43 -> next cycle: instr_valid=0, imem_addr=0x40; following cycle: instr_pc=0x40; pcs 0x10 and 0x14 are never delivered.
REQ-033 redirect to 0xFFFF_FFFC, instr_ready=1 -> delivered pcs 0xFFFF_FFFC, then 0x0, then 0x4.
REQ-034 reset_n pulsed low between edges while the queue is full -> instr_valid, instr and fetch_count read 0 before the next edge; after release, fetch restarts at RESET_PC.
REQ-035 Random instr_ready and redirect over 10k cycles checked against a reference model -> order, pcs and fetch_count all match, and no handshake occurs while empty.
